// File: rtl/bitcount_pkg.sv
// Shared types and mode encodings for the bitcount processor.
package bitcount_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_EQ  = 2'd0;
  localparam logic [1:0] MODE_GE  = 2'd1;
  localparam logic [1:0] MODE_LE  = 2'd2;
  localparam logic [1:0] MODE_ODD = 2'd3;

endpackage

// File: rtl/bitcount_datapath.sv
// Shift/count datapath: latches operand, target and mode, counts set bits,
// and captures the final count and compare result.
module bitcount_datapath
  import bitcount_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             capture,
  input  logic [WIDTH-1:0] operand,
  input  logic [CNT_W-1:0] target,
  input  logic [1:0]       mode,
  output logic             shreg_zero,
  output logic [CNT_W-1:0] count,
  output logic             led
);

  logic [WIDTH-1:0] shreg_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] k_r;
  logic [1:0]       mode_r;
  logic [CNT_W-1:0] count_r;
  logic             led_r;

  // Unsigned compare; a target above WIDTH simply never matches EQ/GE.
  function automatic logic compare_f(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] k,
                                     input logic [1:0]       m);
    case (m)
      MODE_EQ:  compare_f = (c == k);
      MODE_GE:  compare_f = (c >= k);
      MODE_LE:  compare_f = (c <= k);
      MODE_ODD: compare_f = c[0];
      default:  compare_f = 1'b0;
    endcase
  endfunction

  assign shreg_zero = (shreg_r == {WIDTH{1'b0}});
  assign count      = count_r;
  assign led        = led_r;

  // Operand shifting, running count and latched operation parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_r <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      k_r     <= {CNT_W{1'b0}};
      mode_r  <= MODE_EQ;
    end else if (load) begin
      shreg_r <= operand;
      cnt_r   <= {CNT_W{1'b0}};
      k_r     <= target;
      mode_r  <= mode;
    end else if (shift) begin
      shreg_r <= shreg_r >> 1;
      cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, shreg_r[0]};
    end
  end

  // Result registers only move when a scan finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
      led_r   <= 1'b0;
    end else if (capture) begin
      count_r <= cnt_r;
      led_r   <= compare_f(cnt_r, k_r, mode_r);
    end
  end

endmodule

// File: rtl/bitcount_processor.sv
// Popcount-and-compare dedicated processor: control FSM around the
// bitcount datapath, with start/done handshake and registered status.
module bitcount_processor
  import bitcount_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [CNT_W-1:0] K,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             led
);

  state_t state_r;
  state_t state_next_s;
  logic   load_s;
  logic   shift_s;
  logic   capture_s;
  logic   shreg_zero_s;
  logic   busy_r;
  logic   done_r;

  bitcount_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .shift      (shift_s),
    .capture    (capture_s),
    .operand    (N),
    .target     (K),
    .mode       (mode),
    .shreg_zero (shreg_zero_s),
    .count      (count),
    .led        (led)
  );

  // Next-state and datapath control decode.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s       = 1'b1;
          state_next_s = ST_SCAN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (shreg_zero_s) begin
          capture_s    = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          shift_s      = 1'b1;
          state_next_s = ST_SCAN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register; busy/done are registered from the next state so they
  // line up exactly with SCAN and DONE occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ST_SCAN);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_bitcount_processor.sv
// Self-checking bench for bitcount_processor at WIDTH=8 and WIDTH=16,
// directed cases followed by a random sweep against a popcount model.
module tb_bitcount_processor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [7:0]  n8;
  logic [15:0] n16;
  logic [3:0]  k8,  count8;
  logic [4:0]  k16, count16;
  logic [1:0]  mode8, mode16;
  logic        busy8, done8, led8;
  logic        busy16, done16, led16;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  bitcount_processor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .N(n8), .K(k8), .mode(mode8),
    .busy(busy8), .done(done8), .count(count8), .led(led8)
  );

  bitcount_processor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .N(n16), .K(k16), .mode(mode16),
    .busy(busy16), .done(done16), .count(count16), .led(led16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: model computes popcount, latency and compare result.
  task automatic run_op(input bit w16, input logic [15:0] n, input int k,
                        input logic [1:0] m, input string tag, input bit interfere);
    int w, pc, hb, lat, cyc, exp_led;
    bit seen, busy_bad;
    logic [31:0] cnt_before, cnt_obs, led_obs;
    w  = w16 ? 16 : 8;
    pc = 0;
    hb = -1;
    for (int i = 0; i < w; i++) begin
      if (n[i]) begin
        pc++;
        hb = i;
      end
    end
    lat = (hb < 0) ? 1 : hb + 2;
    case (m)
      2'd0:    exp_led = (pc == k) ? 1 : 0;
      2'd1:    exp_led = (pc >= k) ? 1 : 0;
      2'd2:    exp_led = (pc <= k) ? 1 : 0;
      default: exp_led = pc % 2;
    endcase
    cnt_before = w16 ? 32'(count16) : 32'(count8);
    if (w16) begin
      n16 = n; k16 = 5'(k); mode16 = m; start16 = 1'b1;
    end else begin
      n8 = n[7:0]; k8 = 4'(k); mode8 = m; start8 = 1'b1;
    end
    tick();
    start8 = 1'b0; start16 = 1'b0;
    n8 = 8'($urandom); n16 = 16'($urandom); k8 = 4'($urandom); k16 = 5'($urandom);
    mode8 = 2'($urandom); mode16 = 2'($urandom);
    chk({tag, ".busy_after_start"}, w16 ? 32'(busy16) : 32'(busy8), 32'd1);
    chk({tag, ".count_held"}, w16 ? 32'(count16) : 32'(count8), cnt_before);
    cyc = 0; seen = 1'b0; busy_bad = 1'b0;
    while (!seen && cyc < w + 4) begin
      if (interfere && cyc == 2) begin
        n8 = 8'h01; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      tick();
      cyc++;
      seen = w16 ? done16 : done8;
      if (!seen && (w16 ? busy16 : busy8) !== 1'b1) busy_bad = 1'b1;
    end
    start8 = 1'b0;
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    chk({tag, ".latency"}, 32'(cyc), 32'(lat));
    chk({tag, ".busy_in_scan"}, 32'(busy_bad), 32'd0);
    cnt_obs = w16 ? 32'(count16) : 32'(count8);
    led_obs = w16 ? 32'(led16) : 32'(led8);
    chk({tag, ".count"}, cnt_obs, 32'(pc));
    chk({tag, ".led"}, led_obs, 32'(exp_led));
    chk({tag, ".busy_at_done"}, w16 ? 32'(busy16) : 32'(busy8), 32'd0);
    tick();
    chk({tag, ".done_pulse"}, w16 ? 32'(done16) : 32'(done8), 32'd0);
    chk({tag, ".led_hold"}, w16 ? 32'(led16) : 32'(led8), 32'(exp_led));
  endtask

  initial begin
    bit done_after_rst;
    logic [1:0] rm;
    logic [15:0] rn;
    rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
    n8 = 8'h00; n16 = 16'h0000; k8 = 4'd0; k16 = 5'd0; mode8 = 2'd0; mode16 = 2'd0;
    tick(); tick();
    rst = 1'b0;
    chk("reset.busy8", 32'(busy8), 32'd0);
    chk("reset.done8", 32'(done8), 32'd0);
    chk("reset.count8", 32'(count8), 32'd0);
    chk("reset.led8", 32'(led8), 32'd0);
    chk("reset.count16", 32'(count16), 32'd0);
    chk("reset.led16", 32'(led16), 32'd0);

    run_op(1'b0, 16'h00F0, 4, 2'd0, "f0_eq4", 1'b0);
    run_op(1'b0, 16'h0000, 0, 2'd0, "zero_eq0", 1'b0);
    run_op(1'b0, 16'h0000, 1, 2'd1, "zero_ge1", 1'b0);
    run_op(1'b0, 16'h0001, 4, 2'd2, "one_le4", 1'b0);
    run_op(1'b0, 16'h0007, 0, 2'd3, "seven_odd", 1'b0);
    run_op(1'b0, 16'h00FF, 8, 2'd0, "ff_ignore_start", 1'b1);
    run_op(1'b0, 16'h00FF, 9, 2'd0, "ff_eq9", 1'b0);
    run_op(1'b0, 16'h0003, 12, 2'd2, "k_big_le", 1'b0);

    // Reset four cycles into a long scan discards the operation.
    n8 = 8'hFF; k8 = 4'd8; mode8 = 2'd0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.busy", 32'(busy8), 32'd0);
    chk("midrst.done", 32'(done8), 32'd0);
    chk("midrst.count", 32'(count8), 32'd0);
    chk("midrst.led", 32'(led8), 32'd0);
    done_after_rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) done_after_rst = 1'b1;
    end
    chk("midrst.no_done", 32'(done_after_rst), 32'd0);
    run_op(1'b0, 16'h0055, 4, 2'd1, "after_rst", 1'b0);

    run_op(1'b1, 16'h8001, 2, 2'd0, "w16_8001", 1'b0);
    run_op(1'b1, 16'hFFFF, 16, 2'd1, "w16_ffff", 1'b0);

    for (int i = 0; i < 24; i++) begin
      rm = 2'(i % 4);
      rn = 16'($urandom);
      run_op(1'b0, {8'h00, rn[7:0]}, int'($urandom_range(0, 10)), rm, "rand8", 1'b0);
      run_op(1'b1, rn, int'($urandom_range(0, 18)), rm, "rand16", 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
